axis_read_launcher: RTL and testbench

//  Upstream command sequencer for the stream read engine. Accepts (address, length) read

---
 rtl/axis_read_launcher_pkg.sv | 24 ++
 rtl/axis_read_launcher_cmd_fifo.sv | 56 +++++
 rtl/axis_read_launcher.sv | 161 ++++++++++++++++
 tb/tb_axis_read_launcher.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_read_launcher_pkg.sv
// Shared constants for the read launcher and the stream read engine:
// config-bus register map, engine ID and the one-hot FSM encoding.
package axis_read_launcher_pkg;

  localparam int CFG_ID_DEF   = 1;
  localparam int CFG_ADDR_DEF = 23;
  localparam int CFG_DATA_DEF = 24;

  localparam int NUM_STATES  = 5;
  localparam int ST_IDLE_IDX = 0;
  localparam int ST_ID_IDX   = 1;
  localparam int ST_ADDR_IDX = 2;
  localparam int ST_LEN_IDX  = 3;
  localparam int ST_RUN_IDX  = 4;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE = 5'(1 << ST_IDLE_IDX),
    S_ID   = 5'(1 << ST_ID_IDX),
    S_ADDR = 5'(1 << ST_ADDR_IDX),
    S_LEN  = 5'(1 << ST_LEN_IDX),
    S_RUN  = 5'(1 << ST_RUN_IDX)
  } state_e;

endpackage

// File: rtl/axis_read_launcher_cmd_fifo.sv
// Synchronous descriptor FIFO with valid/ready on both sides.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axis_cmd_fifo #(
  parameter int WIDTH  = 64,
  parameter int AWIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH:0]  wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]  rd_ptr_q, rd_ptr_d;
  logic             full, empty, push, pop;

  // Occupancy flags, handshakes and next pointer values
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && !full;
    pop       = out_ready && !empty;
    wr_ptr_d  = wr_ptr_q + {{AWIDTH{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{AWIDTH{1'b0}}, pop};
    out_data  = mem_q[rd_ptr_q[AWIDTH-1:0]];
  end

  // Pointer registers; reset empties the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AWIDTH-1:0]] <= in_data;
    end
  end

endmodule

// File: rtl/axis_read_launcher.sv
// Command sequencer for the stream read engine: queues (address, length)
// descriptors, replays each as ID/addr/len config words, then counts output
// beats and launches the next descriptor only once the stream has drained.
module axis_read_launcher
  import axis_read_launcher_pkg::*;
#(
  parameter int CFG_ID     = CFG_ID_DEF,
  parameter int CFG_ADDR   = CFG_ADDR_DEF,
  parameter int CFG_DATA   = CFG_DATA_DEF,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32,
  parameter int Q_AWIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cmd_addr,
  input  logic [CFG_DWIDTH-1:0] cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  input  logic                  str_valid,
  input  logic                  str_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CFG_AWIDTH-1:0] ID_REG   = CFG_AWIDTH'(CFG_ADDR);
  localparam logic [CFG_AWIDTH-1:0] DATA_REG = CFG_AWIDTH'(CFG_DATA);
  localparam logic [CFG_DWIDTH-1:0] ID_WORD  = CFG_DWIDTH'(CFG_ID);
  localparam logic [CFG_DWIDTH-1:0] ONE      = CFG_DWIDTH'(1);
  localparam logic [CFG_DWIDTH-1:0] ZERO     = '0;

  state_e                  state_q, state_d;
  logic [CFG_DWIDTH-1:0]   addr_q, addr_d;
  logic [CFG_DWIDTH-1:0]   len_q, len_d;
  logic [CFG_DWIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CFG_AWIDTH-1:0]   cfg_addr_q, cfg_addr_d;
  logic [CFG_DWIDTH-1:0]   cfg_data_q, cfg_data_d;
  logic                    cfg_valid_q, cfg_valid_d;
  logic                    done_q, done_d;

  logic [2*CFG_DWIDTH-1:0] fifo_data;
  logic                    fifo_valid;
  logic                    fifo_pop;
  logic [CFG_DWIDTH-1:0]   head_addr, head_len;
  logic                    beat;

  assign head_addr = fifo_data[2*CFG_DWIDTH-1:CFG_DWIDTH];
  assign head_len  = fifo_data[CFG_DWIDTH-1:0];
  assign beat      = str_valid & str_ready;

  axis_cmd_fifo #(
    .WIDTH  (2*CFG_DWIDTH),
    .AWIDTH (Q_AWIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({cmd_addr, cmd_len}),
    .in_valid  (cmd_valid),
    .in_ready  (cmd_ready),
    .out_data  (fifo_data),
    .out_valid (fifo_valid),
    .out_ready (fifo_pop)
  );

  // Next-state logic. The cfg word for a state is prepared on the edge that
  // enters it, so cfg_valid is high exactly while the FSM sits in S_ID/S_ADDR/S_LEN.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    cfg_valid_d = 1'b0;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_valid) begin
          fifo_pop = 1'b1;
          if (head_len == ZERO) begin
            // Empty descriptor retires immediately without touching the engine
            done_d = 1'b1;
          end else begin
            addr_d      = head_addr;
            len_d       = head_len;
            cfg_valid_d = 1'b1;
            cfg_addr_d  = ID_REG;
            cfg_data_d  = ID_WORD;
            state_d     = S_ID;
          end
        end
      end
      S_ID: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = DATA_REG;
        cfg_data_d  = addr_q;
        state_d     = S_ADDR;
      end
      S_ADDR: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = DATA_REG;
        cfg_data_d  = len_q;
        state_d     = S_LEN;
      end
      S_LEN: begin
        beat_cnt_d = len_q;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (beat) begin
          if (beat_cnt_q == ONE) begin
            beat_cnt_d = ZERO;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset abandons any in-flight descriptor
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      done_q      <= done_d;
    end
  end

  // Latched descriptor fields; only read after being loaded on a pop
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_valid = cfg_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_axis_read_launcher.sv
// Directed bench for axis_read_launcher: a transaction-level model predicts
// every output each cycle, and literal expectations pin key timings/values.
module tb_axis_read_launcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        str_valid = 1'b0;
  logic        str_ready = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  axis_read_launcher dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .str_valid (str_valid),
    .str_ready (str_ready),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct packed { logic [31:0] a; logic [31:0] l; } desc_t;
  typedef struct packed { int c; logic [4:0] a; logic [31:0] d; } cfgw_t;

  // Model: pending descriptors, the word list of the active one, beats left
  desc_t       mq[$];
  bit          m_on = 1'b0;
  bit          m_act = 1'b0;
  int          m_k = 0;
  logic [31:0] m_rem = '0;
  logic [4:0]  wa [3];
  logic [31:0] wd [3];
  bit          push_ok;
  desc_t       hd;
  logic        e_ready = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_cv = 1'b0;
  logic [4:0]  e_ca = '0;
  logic [31:0] e_cd = '0;

  // Observation logs
  cfgw_t cfg_log[$];
  int    done_log[$];
  int    beat_edges[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each popped descriptor becomes three config words on consecutive
  // cycles, one settle cycle, then len counted beats and a done pulse.
  always @(posedge clk) begin
    cyc++;
    if (str_valid && str_ready) beat_edges.push_back(cyc);
    if (rst) begin
      mq.delete();
      m_on  = 1'b1;
      m_act = 1'b0;
      m_k   = 0;
      e_cv  = 1'b0;
      e_ca  = '0;
      e_cd  = '0;
      e_done = 1'b0;
    end else begin
      push_ok = cmd_valid && (mq.size() < 4);
      e_done = 1'b0;
      e_cv   = 1'b0;
      if (m_act) begin
        if (m_k < 3) begin
          e_cv = 1'b1; e_ca = wa[m_k]; e_cd = wd[m_k]; m_k++;
        end else if (m_k == 3) begin
          m_k = 4;
        end else if (str_valid && str_ready) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_act = 1'b0; e_done = 1'b1;
          end
        end
      end else if (mq.size() > 0) begin
        hd = mq.pop_front();
        if (hd.l == 0) begin
          e_done = 1'b1;
        end else begin
          m_act = 1'b1; m_rem = hd.l;
          wa[0] = 5'd23; wd[0] = 32'd1;
          wa[1] = 5'd24; wd[1] = hd.a;
          wa[2] = 5'd24; wd[2] = hd.l;
          e_cv = 1'b1; e_ca = wa[0]; e_cd = wd[0]; m_k = 1;
        end
      end
      if (push_ok) mq.push_back({cmd_addr, cmd_len});
    end
    e_busy  = m_act;
    e_ready = (mq.size() < 4);
  end

  // Compare process: every cycle after the first reset edge
  always @(posedge clk) begin
    #1;
    if (cfg_valid === 1'b1) cfg_log.push_back({cyc, cfg_addr, cfg_data});
    if (done === 1'b1) done_log.push_back(cyc);
    if (m_on) begin
      chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, e_ready});
      chk("busy",      {63'd0, busy},      {63'd0, e_busy});
      chk("done",      {63'd0, done},      {63'd0, e_done});
      chk("cfg_valid", {63'd0, cfg_valid}, {63'd0, e_cv});
      chk("cfg_addr",  {59'd0, cfg_addr},  {59'd0, e_ca});
      chk("cfg_data",  {32'd0, cfg_data},  {32'd0, e_cd});
    end
  end

  // Present one descriptor for a single cycle; caller is at a negedge.
  // Returns the cycle number of the edge that sampled it.
  task automatic push(input logic [31:0] a, input logic [31:0] l, output int pc);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    pc = cyc;
  endtask

  task automatic wait_quiet(input bit tog, input string nm);
    int n;
    n = 0;
    while ((m_act || mq.size() != 0) && n < 400) begin
      @(negedge clk);
      if (tog) str_ready = ~str_ready;
      n++;
    end
    n_cmp++;
    if (n >= 400) begin
      n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", nm, n);
    end
    repeat (3) @(negedge clk);
  endtask

  int pc, pc0, pc1, c0, d0, w2, nb, hit;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_cfg_valid", {63'd0, cfg_valid}, 64'd0);
    chk("rst_cfg_addr",  {59'd0, cfg_addr},  64'd0);
    chk("rst_cfg_data",  {32'd0, cfg_data},  64'd0);
    chk("rst_done",      {63'd0, done},      64'd0);

    // Single descriptor, stream always ready
    str_valid = 1'b1; str_ready = 1'b1;
    c0 = cfg_log.size(); d0 = done_log.size();
    push(32'h1000, 32'd4, pc);
    wait_quiet(1'b0, "t1");
    chk("t1_ncfg",   64'(cfg_log.size() - c0), 64'd3);
    chk("t1_w0",     {27'd0, cfg_log[c0].a, cfg_log[c0].d},     {27'd0, 5'd23, 32'd1});
    chk("t1_w1",     {27'd0, cfg_log[c0+1].a, cfg_log[c0+1].d}, {27'd0, 5'd24, 32'h1000});
    chk("t1_w2",     {27'd0, cfg_log[c0+2].a, cfg_log[c0+2].d}, {27'd0, 5'd24, 32'd4});
    chk("t1_w0_cyc", 64'(cfg_log[c0].c),   64'(pc + 1));
    chk("t1_w2_cyc", 64'(cfg_log[c0+2].c), 64'(pc + 3));
    chk("t1_ndone",  64'(done_log.size() - d0), 64'd1);
    chk("t1_done_lat", 64'(done_log[d0] - cfg_log[c0+2].c), 64'd5);

    // Stalled stream: queue fills, later drains in order
    str_valid = 1'b0; str_ready = 1'b1;
    c0 = cfg_log.size(); d0 = done_log.size();
    push(32'h100, 32'd3, pc);
    push(32'h200, 32'd1, pc);
    push(32'h300, 32'd1, pc);
    push(32'h400, 32'd1, pc);
    push(32'h500, 32'd1, pc);
    chk("t2_full", {63'd0, cmd_ready}, 64'd0);
    push(32'h600, 32'd1, pc);
    str_valid = 1'b1;
    wait_quiet(1'b0, "t2");
    chk("t2_ncfg",  64'(cfg_log.size() - c0),  64'd15);
    chk("t2_ndone", 64'(done_log.size() - d0), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_order%0d", i), {32'd0, cfg_log[c0+1+3*i].d}, 64'(32'h100 * (i + 1)));

    // Zero-length descriptor followed by a normal one
    c0 = cfg_log.size(); d0 = done_log.size();
    push(32'h0, 32'd0, pc0);
    push(32'h2000, 32'd2, pc1);
    wait_quiet(1'b0, "t3");
    chk("t3_ndone",    64'(done_log.size() - d0), 64'd2);
    chk("t3_ncfg",     64'(cfg_log.size() - c0),  64'd3);
    chk("t3_zero_cyc", 64'(done_log[d0]), 64'(pc0 + 1));
    chk("t3_addr",     {32'd0, cfg_log[c0+1].d}, 64'h2000);

    // Throttled stream: exactly 8 accepted beats before done
    c0 = cfg_log.size(); d0 = done_log.size();
    str_valid = 1'b1; str_ready = 1'b1;
    push(32'h6000, 32'd8, pc);
    wait_quiet(1'b1, "t4");
    str_ready = 1'b1;
    w2 = cfg_log[c0+2].c;
    nb = 0; hit = 0;
    foreach (beat_edges[i]) begin
      if (beat_edges[i] >= w2 + 2 && beat_edges[i] <= done_log[d0]) nb++;
      if (beat_edges[i] == done_log[d0]) hit = 1;
    end
    chk("t4_beats",     64'(nb),  64'd8);
    chk("t4_last_beat", 64'(hit), 64'd1);

    // Reset while the address word is on the bus
    str_valid = 1'b0;
    c0 = cfg_log.size();
    push(32'h3000, 32'd5, pc);
    push(32'h3100, 32'd1, pc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_cfgv_off", {63'd0, cfg_valid}, 64'd0);
    repeat (5) @(negedge clk);
    chk("t5_ncfg",  64'(cfg_log.size() - c0), 64'd2);
    chk("t5_busy",  {63'd0, busy}, 64'd0);
    chk("t5_ready", {63'd0, cmd_ready}, 64'd1);
    c0 = cfg_log.size();
    str_valid = 1'b1;
    push(32'h4000, 32'd1, pc);
    wait_quiet(1'b0, "t5");
    chk("t5_restart", {27'd0, cfg_log[c0].a, cfg_log[c0].d}, {27'd0, 5'd23, 32'd1});
    chk("t5_ncfg2",   64'(cfg_log.size() - c0), 64'd3);

    // Stray beats while idle are ignored
    d0 = done_log.size();
    str_valid = 1'b1; str_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_nodone", 64'(done_log.size() - d0), 64'd0);
    c0 = cfg_log.size();
    push(32'h5000, 32'd2, pc);
    wait_quiet(1'b0, "t6");
    chk("t6_done_lat", 64'(done_log[d0] - cfg_log[c0+2].c), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
